wave_renderer: RTL and testbench
================================

WAVE_RENDERER -- requirements
Module: wave_renderer

Interface
REQ-001 SHALL have parameters: WIDTH, 128, trace columns/samples per frame; HEIGHT, 128, trace rows; GRID, 16, grid pitch in pixels (power of 2).
REQ-002 SHALL have ports (name direction width meaning): clk in 1 pixel clock, 25 MHz; rst_n in 1 asynchronous active-low reset.
REQ-003 SHALL have: sample_valid in 1 sample strobe; sample_data in 8 unsigned ADC sample; sample_ready out 1 capture accepting samples.
REQ-004 SHALL have: trig_level in 8 trigger threshold; force_trig in 1 trigger on next valid sample.
REQ-005 SHALL have: counterX in 10, counterY in 10, drawArea in 1, hSync in 1, vSync in 1 timing from the raster counter.
REQ-006 SHALL have: red_o, green_o, blue_o out 8 each pixel colour; drawArea_o, hSync_o, vSync_o out 1 each timing delayed to match pixel; frame_swapped out 1 one-cycle pulse on buffer swap.
REQ-007 Clocking/reset: single clock clk; rst_n asynchronous, active-low.

Function
REQ-008 SHALL hold two WIDTH x 8-bit sample buffers (ping-pong): one capture, one display; buf_sel selects capture buffer.
REQ-009 Capture FSM SHALL have states ARM, CAPTURE, DONE.
REQ-010 ARM: sample_ready=1; trigger = sample_valid and (prev_sample < trig_level and sample_data >= trig_level, or force_trig); prev_sample updates on every accepted sample.
REQ-011 On trigger in ARM: triggering sample written at address 0, wr_addr=1, go CAPTURE.
REQ-012 CAPTURE: sample_ready=1; each sample_valid writes at wr_addr, increments; write at WIDTH-1 -> DONE, wr_addr=0.
REQ-013 DONE: sample_ready=0; samples with sample_valid ignored; on vSync rising edge (vSync=1, previous cycle 0): toggle buf_sel, set disp_valid=1, pulse frame_swapped for one cycle, go ARM.
REQ-014 vSync edge in ARM or CAPTURE SHALL NOT swap; first ARM sample after reset has no prior value -- no crossing trigger on it (force_trig still applies).
REQ-015 Render pipeline SHALL be 2 cycles: stage 1 registered read of display buffer at counterX (cur) plus retained previous column value (prev; prev=cur when counterX=0); stage 2 colour decision; outputs registered.
REQ-016 Row mapping: row(s) = HEIGHT-1 - (s >> (8 - log2 HEIGHT)); for HEIGHT=128, row = 127 - s[7:1].
REQ-017 Trace pixel: disp_valid=1, counterX<WIDTH, and min(row(prev),row(cur)) <= counterY <= max(row(prev),row(cur)) -- vertical fill connects adjacent samples.
REQ-018 Grid pixel: counterX mod GRID=0 or counterY mod GRID=0, within drawArea.
REQ-019 Colour priority: drawArea=0 -> 000000; trace -> 00FF00; grid -> 404040; else 000000 (hex R,G,B).
REQ-020 drawArea_o, hSync_o, vSync_o SHALL equal inputs delayed exactly 2 clk cycles.
REQ-021 Buffer write and display read SHALL never address the same buffer in the same cycle.

Reset
REQ-022 On rst_n=0: state ARM, wr_addr=0, buf_sel=0, disp_valid=0, prev-sample-valid=0, all colour outputs 0, drawArea_o/hSync_o/vSync_o=0, frame_swapped=0, sample_ready=0 while asserted.
REQ-023 Reset mid-CAPTURE SHALL abandon the capture; buffer contents are not cleared but are not displayed until disp_valid=1.
REQ-024 After release, sample_ready=1 from first clk edge.

Verification
REQ-025 Reset then full raster with no samples -> grid only: pixel (0,5)=404040, (5,5)=000000, (16,16)=404040; frame_swapped never pulses.
REQ-026 trig_level=0x80, ramp samples 0x00..0xFF step 2 -> trigger at sample 0x80, buffer holds 0x80..0x17E wrapped to 8 bits, DONE after 128 samples, sample_ready=0.
REQ-027 In DONE, vSync 0->1 -> frame_swapped one cycle, buf_sel toggles; next frame pixel (0, 127-0x40)=00FF00.
REQ-028 Constant samples 0x40 via force_trig -> every column lit only at row 95; adjacent samples 0x00,0xFE at x=4,5 -> column 5 lit rows 0..127.
REQ-029 vSync edge during CAPTURE -> no swap; swap on first edge after DONE; samples during DONE dropped.
REQ-030 Assert rst_n=0 mid-CAPTURE -> outputs 0 asynchronously; after release state ARM, disp_valid=0, no trace drawn.

Source files
------------

// File: rtl/wave_renderer.sv
// Dual-buffered oscilloscope trace renderer: captures a triggered frame of
// samples into one buffer while the other is drawn over a grid.
module wave_renderer #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  parameter int GRID   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  output logic       sample_ready,
  input  logic [7:0] trig_level,
  input  logic       force_trig,
  input  logic [9:0] counterX,
  input  logic [9:0] counterY,
  input  logic       drawArea,
  input  logic       hSync,
  input  logic       vSync,
  output logic [7:0] red_o,
  output logic [7:0] green_o,
  output logic [7:0] blue_o,
  output logic       drawArea_o,
  output logic       hSync_o,
  output logic       vSync_o,
  output logic       frame_swapped
);

  localparam int AW    = $clog2(WIDTH);
  localparam int SHIFT = 8 - $clog2(HEIGHT);

  typedef enum logic [1:0] {ARM, CAPTURE, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic            buf_sel_q, buf_sel_d;
  logic            disp_valid_q, disp_valid_d;
  logic [7:0]      prev_sample_q, prev_sample_d;
  logic            prev_vld_q, prev_vld_d;
  logic            frame_swapped_q, frame_swapped_d;
  logic            vs_prev_q;
  logic            rdy_en_q;

  logic            accept, crossing, vs_rise;
  logic            wr_en;
  logic [AW-1:0]   wr_ptr;

  logic [7:0]      mem0 [WIDTH];
  logic [7:0]      mem1 [WIDTH];
  logic [AW-1:0]   rd_addr;
  logic [7:0]      rd_word;

  // Sample value to screen row; larger samples sit higher on the screen.
  function automatic logic [9:0] row_of(input logic [7:0] s);
    row_of = 10'(HEIGHT - 1) - 10'(s >> SHIFT);
  endfunction

  // Ready is held low until the first edge after reset release.
  assign sample_ready  = rdy_en_q & (state_q != DONE);
  assign accept        = sample_valid & sample_ready;
  assign crossing      = prev_vld_q & (prev_sample_q < trig_level) & (sample_data >= trig_level);
  assign vs_rise       = vSync & ~vs_prev_q;
  assign frame_swapped = frame_swapped_q;

  // Capture FSM next-state: arm on trigger, fill the capture buffer, wait for vsync to swap.
  always_comb begin
    state_d         = state_q;
    wr_addr_d       = wr_addr_q;
    buf_sel_d       = buf_sel_q;
    disp_valid_d    = disp_valid_q;
    prev_sample_d   = prev_sample_q;
    prev_vld_d      = prev_vld_q;
    frame_swapped_d = 1'b0;
    wr_en           = 1'b0;
    wr_ptr          = wr_addr_q;
    if (accept) begin
      prev_sample_d = sample_data;
      prev_vld_d    = 1'b1;
    end
    case (state_q)
      ARM: begin
        if (accept && (crossing || force_trig)) begin
          wr_en     = 1'b1;
          wr_ptr    = '0;
          wr_addr_d = AW'(1);
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        if (accept) begin
          wr_en = 1'b1;
          if (wr_addr_q == AW'(WIDTH - 1)) begin
            wr_addr_d = '0;
            state_d   = DONE;
          end else begin
            wr_addr_d = wr_addr_q + AW'(1);
          end
        end
      end
      DONE: begin
        if (vs_rise) begin
          buf_sel_d       = ~buf_sel_q;
          disp_valid_d    = 1'b1;
          frame_swapped_d = 1'b1;
          state_d         = ARM;
        end
      end
      default: state_d = ARM;
    endcase
  end

  // Capture control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ARM;
      wr_addr_q       <= '0;
      buf_sel_q       <= 1'b0;
      disp_valid_q    <= 1'b0;
      prev_sample_q   <= '0;
      prev_vld_q      <= 1'b0;
      frame_swapped_q <= 1'b0;
      vs_prev_q       <= 1'b0;
      rdy_en_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_addr_q       <= wr_addr_d;
      buf_sel_q       <= buf_sel_d;
      disp_valid_q    <= disp_valid_d;
      prev_sample_q   <= prev_sample_d;
      prev_vld_q      <= prev_vld_d;
      frame_swapped_q <= frame_swapped_d;
      vs_prev_q       <= vSync;
      rdy_en_q        <= 1'b1;
    end
  end

  // Sample write into the capture buffer; the display buffer is always the other one.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (buf_sel_q) mem1[wr_ptr] <= sample_data;
      else           mem0[wr_ptr] <= sample_data;
    end
  end

  assign rd_addr = counterX[AW-1:0];
  assign rd_word = buf_sel_q ? mem0[rd_addr] : mem1[rd_addr];

  // ---- stage 1: display buffer read, previous column retained ----
  logic [7:0] cur_p1_q, prev_p1_q;
  logic [9:0] x_p1_q, y_p1_q;
  logic       da_p1_q, hs_p1_q, vs_p1_q, vld_p1_q, xin_p1_q;

  // Stage 1 data: current column sample and the one read the cycle before.
  always_ff @(posedge clk) begin
    cur_p1_q  <= rd_word;
    prev_p1_q <= (counterX == '0) ? rd_word : cur_p1_q;
    x_p1_q    <= counterX;
    y_p1_q    <= counterY;
  end

  // Stage 1 control: timing and trace-enable qualifiers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      da_p1_q  <= 1'b0;
      hs_p1_q  <= 1'b0;
      vs_p1_q  <= 1'b0;
      vld_p1_q <= 1'b0;
      xin_p1_q <= 1'b0;
    end else begin
      da_p1_q  <= drawArea;
      hs_p1_q  <= hSync;
      vs_p1_q  <= vSync;
      vld_p1_q <= disp_valid_q;
      xin_p1_q <= (counterX < 10'(WIDTH));
    end
  end

  // ---- stage 2: colour decision ----
  logic [9:0]  row_cur, row_prev, row_lo, row_hi;
  logic        trace, grid;
  logic [23:0] rgb_d, rgb_p2_q;
  logic        da_p2_q, hs_p2_q, vs_p2_q;

  // Colour select: trace over grid, black outside the draw area.
  always_comb begin
    row_cur  = row_of(cur_p1_q);
    row_prev = row_of(prev_p1_q);
    row_lo   = (row_cur < row_prev) ? row_cur : row_prev;
    row_hi   = (row_cur < row_prev) ? row_prev : row_cur;
    trace    = vld_p1_q & xin_p1_q & (y_p1_q >= row_lo) & (y_p1_q <= row_hi);
    grid     = ((x_p1_q & 10'(GRID - 1)) == '0) | ((y_p1_q & 10'(GRID - 1)) == '0);
    rgb_d    = 24'h000000;
    if (!da_p1_q)  rgb_d = 24'h000000;
    else if (trace) rgb_d = 24'h00FF00;
    else if (grid)  rgb_d = 24'h404040;
  end

  // Stage 2 registers: pixel colour and timing aligned with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p2_q <= '0;
      da_p2_q  <= 1'b0;
      hs_p2_q  <= 1'b0;
      vs_p2_q  <= 1'b0;
    end else begin
      rgb_p2_q <= rgb_d;
      da_p2_q  <= da_p1_q;
      hs_p2_q  <= hs_p1_q;
      vs_p2_q  <= vs_p1_q;
    end
  end

  assign red_o      = rgb_p2_q[23:16];
  assign green_o    = rgb_p2_q[15:8];
  assign blue_o     = rgb_p2_q[7:0];
  assign drawArea_o = da_p2_q;
  assign hSync_o    = hs_p2_q;
  assign vSync_o    = vs_p2_q;

endmodule

// File: tb/tb_wave_renderer.sv
// Bench for wave_renderer: scoreboard model of capture/swap/render plus
// hand-computed pixel probes.
module tb_wave_renderer;
  localparam int W = 128;
  localparam int H = 128;
  localparam int G = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_valid;
  logic [7:0] sample_data;
  logic       sample_ready;
  logic [7:0] trig_level;
  logic       force_trig;
  logic [9:0] counterX, counterY;
  logic       drawArea, hSync, vSync;
  logic [7:0] red_o, green_o, blue_o;
  logic       drawArea_o, hSync_o, vSync_o, frame_swapped;

  wave_renderer #(.WIDTH(W), .HEIGHT(H), .GRID(G)) dut (
    .clk(clk), .rst_n(rst_n),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .trig_level(trig_level), .force_trig(force_trig),
    .counterX(counterX), .counterY(counterY), .drawArea(drawArea), .hSync(hSync), .vSync(vSync),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .drawArea_o(drawArea_o), .hSync_o(hSync_o), .vSync_o(vSync_o),
    .frame_swapped(frame_swapped)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int ph = 0;
  int fs_count = 0;
  int probe_hits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [23:0] rgb;
    logic        da, hs, vs;
    int          x, y, ph;
    bit          live;
  } pix_t;

  byte unsigned disp_m [W];
  byte unsigned cap_m [$];
  bit           dvalid_m, done_m, pvld_m, vsprev_m, ready_m, fs_m;
  byte unsigned prevs_m;
  pix_t         p1_m, out_m;

  int pq_ph [$], pq_x [$], pq_y [$];
  logic [23:0] pq_rgb [$];

  task automatic add_probe(input int p, input int x, input int y, input logic [23:0] c);
    pq_ph.push_back(p); pq_x.push_back(x); pq_y.push_back(y); pq_rgb.push_back(c);
  endtask

  function automatic int row_m(input int s);
    return H - 1 - (s * H) / 256;
  endfunction

  function automatic pix_t expect_pix();
    pix_t r;
    int x, y, a, b, lo, hi;
    bit tr, gr;
    x = int'(counterX); y = int'(counterY);
    tr = 1'b0;
    if (dvalid_m && x < W) begin
      a = row_m(int'(disp_m[x]));
      b = row_m(int'(disp_m[(x == 0) ? 0 : x - 1]));
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      tr = (y >= lo) && (y <= hi);
    end
    gr = (x % G == 0) || (y % G == 0);
    if (!drawArea) r.rgb = 24'h000000;
    else if (tr)   r.rgb = 24'h00FF00;
    else if (gr)   r.rgb = 24'h404040;
    else           r.rgb = 24'h000000;
    r.da = drawArea; r.hs = hSync; r.vs = vSync;
    r.x = x; r.y = y; r.ph = ph; r.live = 1'b1;
    return r;
  endfunction

  function automatic pix_t blank_pix();
    pix_t r;
    r.rgb = '0; r.da = 0; r.hs = 0; r.vs = 0; r.x = 0; r.y = 0; r.ph = 0; r.live = 0;
    return r;
  endfunction

  // Compare current DUT outputs with the model, then advance the model to the next edge.
  always @(negedge clk) begin
    bit done_old, acc;
    if (!rst_n) begin
      dvalid_m = 0; cap_m.delete(); done_m = 0; pvld_m = 0; prevs_m = 0;
      vsprev_m = 0; ready_m = 0; fs_m = 0;
      p1_m = blank_pix(); out_m = blank_pix();
    end
    chk("pixel", {8'h0, red_o, green_o, blue_o}, {8'h0, out_m.rgb});
    chk("timing", {29'h0, drawArea_o, hSync_o, vSync_o}, {29'h0, out_m.da, out_m.hs, out_m.vs});
    chk("ready", {31'h0, sample_ready}, {31'h0, ready_m && !done_m});
    chk("swap", {31'h0, frame_swapped}, {31'h0, fs_m});
    if (out_m.live) begin
      for (int k = 0; k < pq_ph.size(); k++) begin
        if (pq_ph[k] == out_m.ph && pq_x[k] == out_m.x && pq_y[k] == out_m.y) begin
          probe_hits++;
          chk($sformatf("probe_p%0d_x%0d_y%0d", pq_ph[k], pq_x[k], pq_y[k]),
              {8'h0, red_o, green_o, blue_o}, {8'h0, pq_rgb[k]});
        end
      end
    end
    if (frame_swapped === 1'b1) fs_count++;
    if (rst_n) begin
      pix_t nw;
      nw = expect_pix();
      out_m = p1_m;
      p1_m = nw;
      done_old = done_m;
      acc = sample_valid && ready_m && !done_old;
      fs_m = 0;
      if (acc) begin
        if (cap_m.size() == 0) begin
          if (force_trig || (pvld_m && prevs_m < trig_level && sample_data >= trig_level))
            cap_m.push_back(sample_data);
        end else begin
          cap_m.push_back(sample_data);
        end
        if (cap_m.size() == W) done_m = 1;
        prevs_m = sample_data;
        pvld_m = 1;
      end
      if (done_old && vSync && !vsprev_m) begin
        for (int i = 0; i < W; i++) disp_m[i] = cap_m[i];
        dvalid_m = 1; cap_m.delete(); done_m = 0; fs_m = 1;
      end
      vsprev_m = vSync;
      ready_m = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    counterX = 10'd140; counterY = 10'd140; drawArea = 0; hSync = 0; vSync = 0;
  endtask

  task automatic line(input int y);
    for (int x = 0; x < 132; x++) begin
      counterX = 10'(x); counterY = 10'(y);
      drawArea = (x < W) && (y < H);
      hSync = (x >= 128) && (x < 131);
      vSync = 0;
      tick();
    end
    idle();
  endtask

  task automatic vs_pulse();
    idle();
    vSync = 1; tick(); tick();
    vSync = 0; tick(); tick();
  endtask

  task automatic send(input logic [7:0] d, input logic ft, input logic vs);
    sample_valid = 1; sample_data = d; force_trig = ft; vSync = vs;
    tick();
    force_trig = 0; vSync = 0;
  endtask

  initial begin
    rst_n = 0; sample_valid = 0; sample_data = 0; force_trig = 0; trig_level = 8'h80;
    idle();
    add_probe(1, 0, 5, 24'h404040);   add_probe(1, 5, 5, 24'h000000);
    add_probe(1, 16, 16, 24'h404040);
    add_probe(2, 0, 63, 24'h00FF00);  add_probe(2, 0, 62, 24'h404040);
    add_probe(2, 1, 62, 24'h00FF00);  add_probe(2, 1, 61, 24'h000000);
    add_probe(2, 127, 64, 24'h00FF00); add_probe(2, 127, 61, 24'h000000);
    add_probe(3, 10, 95, 24'h00FF00); add_probe(3, 10, 94, 24'h000000);
    add_probe(3, 5, 0, 24'h00FF00);   add_probe(3, 5, 127, 24'h00FF00);
    add_probe(3, 5, 30, 24'h00FF00);  add_probe(3, 4, 127, 24'h00FF00);
    add_probe(3, 4, 94, 24'h000000);  add_probe(3, 6, 30, 24'h00FF00);
    add_probe(3, 7, 30, 24'h000000);  add_probe(3, 7, 95, 24'h00FF00);
    add_probe(4, 10, 95, 24'h000000); add_probe(4, 16, 95, 24'h404040);
    add_probe(4, 5, 30, 24'h000000);

    repeat (3) tick();
    rst_n = 1;
    chk("ready_before_edge", {31'h0, sample_ready}, 32'd0);
    tick();
    chk("ready_after_edge", {31'h0, sample_ready}, 32'd1);

    // Empty frame: grid only, no swap even on vsync.
    ph = 1;
    for (int y = 0; y < H; y++) line(y);
    ph = 0;
    vs_pulse();
    chk("no_swap_empty", fs_count, 0);

    // Rising ramp, trigger at 0x80, 128 samples wrap through 0xFE..0x7E.
    for (int i = 0; i < 192; i++) send(8'(2 * i), 1'b0, 1'b0);
    sample_valid = 0; tick();
    chk("ready_done", {31'h0, sample_ready}, 32'd0);
    for (int i = 0; i < 3; i++) send(8'h11, 1'b0, 1'b0);
    sample_valid = 0;
    vs_pulse();
    chk("swap_after_ramp", fs_count, 1);
    ph = 2;
    for (int y = 60; y <= 66; y++) line(y);
    ph = 0;

    // Forced constant trace with a full-height spike; vsync mid-capture must not swap.
    for (int i = 0; i < W; i++)
      send((i == 4) ? 8'h00 : (i == 5) ? 8'hFE : 8'h40, i == 0, i == 50);
    sample_valid = 0; tick();
    chk("no_swap_capture", fs_count, 1);
    send(8'h22, 1'b0, 1'b0); send(8'h23, 1'b0, 1'b0);
    sample_valid = 0;
    vs_pulse();
    chk("swap_after_const", fs_count, 2);
    ph = 3;
    line(0); line(30); line(94); line(95); line(127);
    ph = 0;

    // Reset in the middle of a capture while a trace line is on screen.
    for (int x = 0; x < 132; x++) begin
      if (x == 40) begin
        chk("green_before_reset", {24'h0, green_o}, 32'h0000_00FF);
        rst_n = 0;
        #5;
        chk("rgb_async_reset", {8'h0, red_o, green_o, blue_o}, 32'h0);
        chk("ready_in_reset", {31'h0, sample_ready}, 32'd0);
        break;
      end
      counterX = 10'(x); counterY = 10'd95; drawArea = 1; hSync = 0; vSync = 0;
      sample_valid = 1; sample_data = 8'h40; force_trig = (x == 0);
      tick();
    end
    sample_valid = 0; force_trig = 0;
    idle();
    repeat (3) tick();
    rst_n = 1;
    tick();
    ph = 4;
    line(30); line(95);
    ph = 0;
    repeat (3) tick();
    chk("probe_hits", probe_hits, 22);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
